sar_search: RTL and testbench

Successive-approximation search controller that drives the A operand of a magnitude comparator and consumes its L/E/G flags to recover the hidden B operand bit by bit. The controller sits on the opposite side of the comparator interface: it generates trial values and reacts to the comparison result. It pairs directly with the team's 2-bit `comparator` at the default width and scales to wider comparators via a parameter. It serves as the search engine for threshold/ADC-style front ends built on the comparator family.

---
 rtl/sar_search_pkg.sv | 24 ++
 rtl/sar_search_if.sv | 26 ++
 rtl/sar_search.sv | 103 ++++++++++
 tb/tb_sar_search.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sar_search_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_search_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TEST = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 8;

  // Bit-index counter width: $clog2(w), but never narrower than one bit.
  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int IDX_W_DEFAULT = idx_width(2);

  // Comparator flags {L,E,G} are valid only when exactly one is set.
  function automatic logic flags_ok(input logic l, input logic e, input logic g);
    return (l ^ e ^ g) & ~(l & e & g);
  endfunction

endpackage

// File: rtl/sar_search_if.sv
// Controller <-> host/comparator signal bundle.
interface sar_search_if #(
  parameter int WIDTH = 2
);
  logic             start;
  logic [WIDTH-1:0] trial;
  logic             cmp_l;
  logic             cmp_e;
  logic             cmp_g;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  // Host side: kicks off searches and returns comparator flags.
  modport master (
    output start, cmp_l, cmp_e, cmp_g,
    input  trial, busy, done, result, err
  );

  // Search controller side.
  modport slave (
    input  start, cmp_l, cmp_e, cmp_g,
    output trial, busy, done, result, err
  );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation controller: walks trial from MSB to LSB using the
// comparator's L/E/G verdict to recover the hidden B operand.
module sar_search
  import sar_search_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  sar_search_if.slave  bus
);

  localparam int IW = idx_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] upd;
  logic [IW-1:0]    idx_q, idx_d;
  logic             err_q, err_d;

  // State, trial, bit index and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      trial_q  <= '0;
      idx_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Next-state: one bit resolved per TEST cycle, early exit on E or bad flags.
  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    idx_d    = idx_q;
    result_d = result_q;
    err_d    = err_q;
    upd      = trial_q;
    case (state_q)
      IDLE: begin
        trial_d = '0;
        if (bus.start) begin
          trial_d = WIDTH'(1) << (WIDTH - 1);
          idx_d   = IW'(WIDTH - 1);
          err_d   = 1'b0;
          state_d = TEST;
        end
      end
      TEST: begin
        if (!flags_ok(bus.cmp_l, bus.cmp_e, bus.cmp_g)) begin
          err_d    = 1'b1;
          result_d = trial_q;
          trial_d  = '0;
          state_d  = DONE;
        end else if (bus.cmp_e) begin
          result_d = trial_q;
          trial_d  = '0;
          state_d  = DONE;
        end else if (bus.cmp_l && idx_q == '0) begin
          // B above the fully-converged trial cannot happen with a sane comparator.
          err_d    = 1'b1;
          result_d = trial_q;
          trial_d  = '0;
          state_d  = DONE;
        end else begin
          if (bus.cmp_g) upd[idx_q] = 1'b0;
          if (idx_q != '0) begin
            upd[idx_q - 1'b1] = 1'b1;
            idx_d   = idx_q - 1'b1;
            trial_d = upd;
          end else begin
            result_d = upd;
            trial_d  = '0;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        trial_d = '0;
        state_d = IDLE;
      end
      default: begin
        trial_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.trial  = trial_q;
  assign bus.busy   = (state_q == TEST);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search at WIDTH 2, 4 and 8 with a behavioural comparator.
module tb_sar_search;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] b2, b4, b8;
  logic       frc;
  logic [2:0] ff;   // forced {L,E,G} for the WIDTH=2 instance
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  sar_search_if #(.WIDTH(2)) i2 ();
  sar_search_if #(.WIDTH(4)) i4 ();
  sar_search_if #(.WIDTH(8)) i8 ();

  sar_search #(.WIDTH(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));
  sar_search #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4.slave));
  sar_search #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8.slave));

  // Behavioural comparators (WIDTH=2 one can be overridden)
  assign i2.cmp_l = frc ? ff[2] : (i2.trial <  b2[1:0]);
  assign i2.cmp_e = frc ? ff[1] : (i2.trial == b2[1:0]);
  assign i2.cmp_g = frc ? ff[0] : (i2.trial >  b2[1:0]);
  assign i4.cmp_l = (i4.trial <  b4[3:0]);
  assign i4.cmp_e = (i4.trial == b4[3:0]);
  assign i4.cmp_g = (i4.trial >  b4[3:0]);
  assign i8.cmp_l = (i8.trial <  b8);
  assign i8.cmp_e = (i8.trial == b8);
  assign i8.cmp_g = (i8.trial >  b8);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] g_trial(input int w);
    case (w)
      2:       return {6'd0, i2.trial};
      4:       return {4'd0, i4.trial};
      default: return i8.trial;
    endcase
  endfunction

  function automatic logic [7:0] g_result(input int w);
    case (w)
      2:       return {6'd0, i2.result};
      4:       return {4'd0, i4.result};
      default: return i8.result;
    endcase
  endfunction

  // {busy, done, err}
  function automatic logic [2:0] g_st(input int w);
    case (w)
      2:       return {i2.busy, i2.done, i2.err};
      4:       return {i4.busy, i4.done, i4.err};
      default: return {i8.busy, i8.done, i8.err};
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      2:       i2.start = v;
      4:       i4.start = v;
      default: i8.start = v;
    endcase
  endtask

  task automatic set_b(input int w, input logic [7:0] b);
    case (w)
      2:       b2 = b;
      4:       b4 = b;
      default: b8 = b;
    endcase
  endtask

  // One search: edges counts the start edge as 1; trace collects trials while busy.
  // Returns one cycle after done, i.e. in IDLE, ready for a back-to-back start.
  task automatic run(input int w, input logic [7:0] b, output int busy_n, output int edges,
                     output logic [7:0] res, output logic e, output logic [63:0] trace);
    logic [2:0] st;
    bit fin;
    int ov;
    fin = 0; ov = 0; busy_n = 0; trace = '0; res = '0; e = 1'b0;
    set_b(w, b);
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    edges = 1;
    for (int k = 0; k < w + 3 && !fin; k++) begin
      st = g_st(w);
      if (st[2] && st[1]) ov++;
      if (st[1]) begin
        fin = 1;
        res = g_result(w);
        e   = st[0];
      end else begin
        if (st[2]) begin
          busy_n++;
          trace = {trace[55:0], g_trial(w)};
        end
        @(posedge clk); #1;
        edges++;
      end
    end
    chk("done_seen", 64'(fin), 64'd1);
    chk("busy_done_overlap", 64'(ov), 64'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(g_st(w)[1]), 64'd0);
  endtask

  int         bn, ed;
  logic [7:0] res;
  logic       er;
  logic [63:0] tr;

  initial begin
    frc = 1'b0; ff = 3'b000;
    b2 = '0; b4 = '0; b8 = '0;
    i2.start = 1'b0; i4.start = 1'b0; i8.start = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("rst_trial2",  64'(g_trial(2)), 64'd0);
    chk("rst_st2",     64'(g_st(2)), 64'd0);
    chk("rst_result2", 64'(g_result(2)), 64'd0);
    chk("rst_trial8",  64'(g_trial(8)), 64'd0);
    chk("rst_st8",     64'(g_st(8)), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // B=2: immediate E on first trial
    run(2, 8'd2, bn, ed, res, er, tr);
    chk("b2_edges", 64'(ed), 64'd2);
    chk("b2_busy",  64'(bn), 64'd1);
    chk("b2_trace", tr, 64'h02);
    chk("b2_res",   64'(res), 64'd2);
    chk("b2_err",   64'(er), 64'd0);
    @(posedge clk); #1;
    chk("b2_res_held", 64'(g_result(2)), 64'd2);

    // B=0: G, G
    run(2, 8'd0, bn, ed, res, er, tr);
    chk("b0_edges", 64'(ed), 64'd3);
    chk("b0_trace", tr, 64'h0201);
    chk("b0_res",   64'(res), 64'd0);
    chk("b0_err",   64'(er), 64'd0);

    // B=3: L, then E
    run(2, 8'd3, bn, ed, res, er, tr);
    chk("b3_edges", 64'(ed), 64'd3);
    chk("b3_trace", tr, 64'h0203);
    chk("b3_res",   64'(res), 64'd3);
    chk("b3_err",   64'(er), 64'd0);

    // Forced 000 on first TEST cycle
    frc = 1'b1; ff = 3'b000;
    run(2, 8'd0, bn, ed, res, er, tr);
    chk("f000_edges", 64'(ed), 64'd2);
    chk("f000_res",   64'(res), 64'd2);
    chk("f000_err",   64'(er), 64'd1);

    // Forced L: keeps bit1, then L at index 0 is inconsistent
    ff = 3'b100;
    run(2, 8'd0, bn, ed, res, er, tr);
    chk("fL_trace", tr, 64'h0203);
    chk("fL_res",   64'(res), 64'd3);
    chk("fL_err",   64'(er), 64'd1);
    frc = 1'b0;

    // WIDTH=8, B=A5: start ignored while busy, then async reset mid-search
    set_b(8, 8'hA5);
    i8.start = 1'b1;
    @(posedge clk); #1; i8.start = 1'b0;
    chk("w8_t1", 64'(g_trial(8)), 64'h80);
    @(posedge clk); #1;
    chk("w8_t2", 64'(g_trial(8)), 64'hC0);
    i8.start = 1'b1;
    @(posedge clk); #1; i8.start = 1'b0;
    chk("w8_start_ignored", 64'(g_trial(8)), 64'hA0);
    chk("w8_busy", 64'(g_st(8)), 64'b100);
    #2 rst_n = 1'b0;
    #1;
    chk("w8_rst_trial",  64'(g_trial(8)), 64'd0);
    chk("w8_rst_st",     64'(g_st(8)), 64'd0);
    chk("w8_rst_result", 64'(g_result(8)), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("w8_no_autostart", 64'(g_st(8)), 64'd0);
    run(8, 8'hA5, bn, ed, res, er, tr);
    chk("w8_res",   64'(res), 64'hA5);
    chk("w8_err",   64'(er), 64'd0);
    chk("w8_trace", tr, 64'h80C0A0B0A8A4A6A5);
    chk("w8_busy_le8", 64'(bn <= 8), 64'd1);
    chk("w8_edges", 64'(ed), 64'd9);

    // Exhaustive, back-to-back searches
    for (int b = 0; b < 4; b++) begin
      run(2, 8'(b), bn, ed, res, er, tr);
      chk("ex2_res", 64'(res), 64'(b));
      chk("ex2_err", 64'(er), 64'd0);
      chk("ex2_busy_le", 64'(bn <= 2), 64'd1);
    end
    for (int b = 0; b < 16; b++) begin
      run(4, 8'(b), bn, ed, res, er, tr);
      chk("ex4_res", 64'(res), 64'(b));
      chk("ex4_err", 64'(er), 64'd0);
      chk("ex4_busy_le", 64'(bn <= 4), 64'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
